// File: rtl/ext_ram_arbiter.sv
// ext_ram_arbiter: round-robin arbiter and command sequencer for the
// single-port synchronous-read external LLR RAM of the LDPC decoder.
// Grants one client per cycle (with optional burst locking), registers the
// RAM command, and routes read data back to the issuing client after a fixed
// two-cycle latency using a small tag pipeline.
module ext_ram_arbiter #(
  parameter int DATA_WIDTH = 5,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REQ    = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [ADDR_WIDTH-1:0]         ram_address,
  output logic [DATA_WIDTH-1:0]         ram_data_in,
  output logic                          ram_we,
  output logic                          ram_cs,
  input  logic [DATA_WIDTH-1:0]         ram_data_out
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

  // Arbitration state
  logic [IDW-1:0]        rr_ptr;
  logic                  owner_vld;
  logic [IDW-1:0]        owner_id;

  // Combinational selection results
  logic [NUM_REQ-1:0]    gnt_raw;
  logic                  sel_vld;
  logic [IDW-1:0]        sel_id;
  logic [IDW-1:0]        rr_sel;
  int                    rr_idx;
  logic                  sel_we;
  logic                  sel_lock;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // Read-tag pipeline: stage 0 tracks the command now on the RAM port,
  // stage 1 tracks the data now coming out of the RAM.
  logic                  tag0_vld;
  logic [IDW-1:0]        tag0_id;
  logic                  tag1_vld;
  logic [IDW-1:0]        tag1_id;

  // Pick the lock owner if it still requests, otherwise the first requester
  // at or after rr_ptr, wrapping around the client list.
  always_comb begin
    gnt_raw = '0;
    sel_vld = 1'b0;
    sel_id  = '0;
    rr_idx  = 0;
    rr_sel  = '0;
    if (owner_vld && req[owner_id]) begin
      gnt_raw[owner_id] = 1'b1;
      sel_vld           = 1'b1;
      sel_id            = owner_id;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        rr_idx = (int'(rr_ptr) + k) % NUM_REQ;
        rr_sel = IDW'(rr_idx);
        if (!sel_vld && req[rr_sel]) begin
          gnt_raw[rr_sel] = 1'b1;
          sel_vld         = 1'b1;
          sel_id          = rr_sel;
        end
      end
    end
  end

  // Grant is held at zero while reset is asserted so no client sees an accept.
  assign gnt = rst_n ? gnt_raw : '0;

  // Multiplex the winning client's command fields out of the packed buses.
  always_comb begin
    sel_we    = 1'b0;
    sel_lock  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_id == IDW'(i)) begin
        sel_we    = req_we[i];
        sel_lock  = req_lock[i];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Register the accepted command onto the RAM port; address and data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_cs      <= 1'b0;
      ram_we      <= 1'b0;
      ram_address <= '0;
      ram_data_in <= '0;
    end else if (sel_vld) begin
      ram_cs      <= 1'b1;
      ram_we      <= sel_we;
      ram_address <= sel_addr;
      ram_data_in <= sel_we ? sel_wdata : '0;
    end else begin
      ram_cs      <= 1'b0;
      ram_we      <= 1'b0;
    end
  end

  // Advance the round-robin pointer past the winner and track burst ownership.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      owner_vld <= 1'b0;
      owner_id  <= '0;
    end else if (sel_vld) begin
      rr_ptr    <= (sel_id == LAST_ID) ? '0 : sel_id + 1'b1;
      owner_vld <= sel_lock;
      owner_id  <= sel_id;
    end else begin
      owner_vld <= 1'b0;
    end
  end

  // Shift read tags alongside the RAM's two-cycle read path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag0_vld <= 1'b0;
      tag0_id  <= '0;
      tag1_vld <= 1'b0;
      tag1_id  <= '0;
    end else begin
      tag0_vld <= sel_vld & ~sel_we;
      tag0_id  <= sel_id;
      tag1_vld <= tag0_vld;
      tag1_id  <= tag0_id;
    end
  end

  // Steer RAM output data to the tagged client; data reads zero when unqualified.
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (tag1_vld) begin
      rvalid[tag1_id] = 1'b1;
      rdata           = ram_data_out;
    end
  end

endmodule

// File: tb/tb_ext_ram_arbiter.sv
// tb_ext_ram_arbiter: scenario tasks drive the arbiter, check grants inline,
// and push expected RAM commands and read returns into queues that a
// negedge monitor pops and compares against the DUT outputs.
module tb_ext_ram_arbiter;

  localparam int DW = 5;
  localparam int AW = 8;
  localparam int NR = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req;
  logic [NR-1:0]    req_we;
  logic [NR-1:0]    req_lock;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    gnt;
  logic [NR-1:0]    rvalid;
  logic [DW-1:0]    rdata;
  logic [AW-1:0]    ram_address;
  logic [DW-1:0]    ram_data_in;
  logic             ram_we;
  logic             ram_cs;
  logic [DW-1:0]    ram_data_out;

  ext_ram_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_REQ   (NR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_we      (req_we),
    .req_lock    (req_lock),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .gnt         (gnt),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .ram_address (ram_address),
    .ram_data_in (ram_data_in),
    .ram_we      (ram_we),
    .ram_cs      (ram_cs),
    .ram_data_out(ram_data_out)
  );

  // Free-running clock
  always #5 clk = ~clk;

  int cyc = 0;
  // Cycle counter used to time expected responses
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural synchronous-read RAM
  logic [DW-1:0] mem [256];
  logic [DW-1:0] ram_q;
  logic [DW-1:0] ref_mem [256];

  function automatic logic [DW-1:0] preload(input int a);
    return DW'((a * 7 + 3) % 32);
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     <= preload(i);
      ref_mem[i]  = preload(i);
    end
    ram_q <= '0;
  end

  // RAM port: write or registered read on chip select
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_address] <= ram_data_in;
      else        ram_q <= mem[ram_address];
    end
  end
  assign ram_data_out = ram_q;

  // Scoreboard
  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } rd_exp_t;

  typedef struct {
    int            due;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_exp_t;

  rd_exp_t  rd_q[$];
  cmd_exp_t cmd_q[$];
  int       n_cmp  = 0;
  int       n_fail = 0;
  bit       mon_en = 1'b0;

  function automatic logic [NR-1:0] onehot(input int g);
    return NR'(1) << g;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_client(input int i, input logic r, input logic w, input logic l,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]               = r;
    req_we[i]            = w;
    req_lock[i]          = l;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic clear_clients();
    for (int i = 0; i < NR; i++) set_client(i, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // Record the consequences of an accept in the current cycle
  task automatic expect_accept(input int g, input logic we, input logic [AW-1:0] a,
                               input logic [DW-1:0] d);
    cmd_exp_t c;
    rd_exp_t  r;
    c.due  = cyc + 1;
    c.we   = we;
    c.addr = a;
    c.data = we ? d : '0;
    cmd_q.push_back(c);
    if (we) begin
      ref_mem[a] = d;
    end else begin
      r.due  = cyc + 2;
      r.id   = g;
      r.data = ref_mem[a];
      rd_q.push_back(r);
    end
  endtask

  logic [NR-1:0] mon_rv;
  logic [DW-1:0] mon_rd;
  rd_exp_t       mon_r;
  cmd_exp_t      mon_c;

  // Compare read returns and RAM commands against the scoreboard every cycle
  always @(negedge clk) begin
    if (mon_en) begin
      mon_rv = '0;
      mon_rd = '0;
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        mon_r  = rd_q.pop_front();
        mon_rv = onehot(mon_r.id);
        mon_rd = mon_r.data;
      end
      n_cmp++;
      if (rvalid !== mon_rv || rdata !== mon_rd) begin
        n_fail++;
        $display("[TB] FAIL read_return cyc %0d: rvalid=%b rdata=%h, required rvalid=%b rdata=%h",
                 cyc, rvalid, rdata, mon_rv, mon_rd);
      end
      if (cmd_q.size() > 0 && cmd_q[0].due == cyc) begin
        mon_c = cmd_q.pop_front();
        n_cmp++;
        if (ram_cs !== 1'b1 || ram_we !== mon_c.we || ram_address !== mon_c.addr ||
            ram_data_in !== mon_c.data) begin
          n_fail++;
          $display("[TB] FAIL ram_cmd cyc %0d: cs=%b we=%b addr=%h din=%h, required cs=1 we=%b addr=%h din=%h",
                   cyc, ram_cs, ram_we, ram_address, ram_data_in, mon_c.we, mon_c.addr, mon_c.data);
        end
      end else begin
        n_cmp++;
        if (ram_cs !== 1'b0 || ram_we !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL ram_idle cyc %0d: cs=%b we=%b, required cs=0 we=0", cyc, ram_cs, ram_we);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b1;
    clear_clients();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({gnt, rvalid, rdata, ram_cs, ram_we, ram_address, ram_data_in} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: gnt=%b rvalid=%b rdata=%h cs=%b we=%b addr=%h din=%h, required all 0",
               gnt, rvalid, rdata, ram_cs, ram_we, ram_address, ram_data_in);
    end
    set_client(1, 1'b1, 1'b0, 1'b0, 8'h05, '0);
    #1;
    n_cmp++;
    if (gnt !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_gnt: gnt=%b, required 000", gnt);
    end
    clear_clients();
    rst_n = 1'b1;
    mon_en = 1'b1;
    next_cycle();
    next_cycle();
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < NR; i++) set_client(i, 1'b1, 1'b0, 1'b0, AW'(i), '0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if (gnt !== onehot(k % NR)) begin
        n_fail++;
        $display("[TB] FAIL rr_gnt step %0d: gnt=%b, required %b", k, gnt, onehot(k % NR));
      end
      expect_accept(k % NR, 1'b0, AW'(k % NR), '0);
      next_cycle();
    end
    clear_clients();
    next_cycle();
  endtask

  task automatic test_single_client();
    set_client(0, 1'b1, 1'b1, 1'b0, 8'h12, 5'h1B);
    @(negedge clk);
    n_cmp++;
    if (gnt !== 3'b001) begin
      n_fail++;
      $display("[TB] FAIL single_wr_gnt: gnt=%b, required 001", gnt);
    end
    expect_accept(0, 1'b1, 8'h12, 5'h1B);
    next_cycle();
    set_client(0, 1'b1, 1'b0, 1'b0, 8'h12, '0);
    @(negedge clk);
    n_cmp++;
    if (gnt !== 3'b001) begin
      n_fail++;
      $display("[TB] FAIL single_rd_gnt: gnt=%b, required 001", gnt);
    end
    expect_accept(0, 1'b0, 8'h12, '0);
    next_cycle();
    clear_clients();
    repeat (3) next_cycle();
  endtask

  task automatic test_lock_burst();
    set_client(0, 1'b1, 1'b0, 1'b0, 8'h20, '0);
    set_client(1, 1'b1, 1'b0, 1'b1, 8'h21, '0);
    set_client(2, 1'b1, 1'b0, 1'b0, 8'h22, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (gnt !== 3'b010) begin
        n_fail++;
        $display("[TB] FAIL lock_gnt step %0d: gnt=%b, required 010", k, gnt);
      end
      expect_accept(1, 1'b0, 8'h21, '0);
      next_cycle();
    end
    set_client(1, 1'b0, 1'b0, 1'b0, 8'h21, '0);
    set_client(2, 1'b1, 1'b0, 1'b1, 8'h22, '0);
    @(negedge clk);
    n_cmp++;
    if (gnt !== 3'b100) begin
      n_fail++;
      $display("[TB] FAIL lock_release_gnt: gnt=%b, required 100", gnt);
    end
    expect_accept(2, 1'b0, 8'h22, '0);
    next_cycle();
  endtask

  task automatic test_lock_abandon();
    @(negedge clk);
    n_cmp++;
    if (gnt !== 3'b100) begin
      n_fail++;
      $display("[TB] FAIL owner_hold_gnt: gnt=%b, required 100", gnt);
    end
    expect_accept(2, 1'b0, 8'h22, '0);
    next_cycle();
    set_client(2, 1'b0, 1'b0, 1'b1, 8'h22, '0);
    @(negedge clk);
    n_cmp++;
    if (gnt !== 3'b001) begin
      n_fail++;
      $display("[TB] FAIL abandon_gnt: gnt=%b, required 001", gnt);
    end
    expect_accept(0, 1'b0, 8'h20, '0);
    next_cycle();
    clear_clients();
    repeat (3) next_cycle();
  endtask

  task automatic test_wrap_boundary();
    set_client(2, 1'b1, 1'b1, 1'b0, 8'hFF, 5'h1F);
    @(negedge clk);
    n_cmp++;
    if (gnt !== 3'b100) begin
      n_fail++;
      $display("[TB] FAIL wrap_wr_gnt: gnt=%b, required 100", gnt);
    end
    expect_accept(2, 1'b1, 8'hFF, 5'h1F);
    next_cycle();
    clear_clients();
    set_client(1, 1'b1, 1'b0, 1'b0, 8'hFF, '0);
    @(negedge clk);
    n_cmp++;
    if (gnt !== 3'b010) begin
      n_fail++;
      $display("[TB] FAIL wrap_rd_ff_gnt: gnt=%b, required 010", gnt);
    end
    expect_accept(1, 1'b0, 8'hFF, '0);
    next_cycle();
    clear_clients();
    set_client(0, 1'b1, 1'b0, 1'b0, 8'h00, '0);
    @(negedge clk);
    n_cmp++;
    if (gnt !== 3'b001) begin
      n_fail++;
      $display("[TB] FAIL wrap_rd_00_gnt: gnt=%b, required 001", gnt);
    end
    expect_accept(0, 1'b0, 8'h00, '0);
    next_cycle();
    clear_clients();
    repeat (3) next_cycle();
  endtask

  task automatic test_reset_midburst();
    set_client(0, 1'b1, 1'b0, 1'b0, 8'h30, '0);
    set_client(1, 1'b1, 1'b0, 1'b0, 8'h31, '0);
    set_client(2, 1'b1, 1'b0, 1'b1, 8'h32, '0);
    @(negedge clk);
    n_cmp++;
    if (gnt !== 3'b010) begin
      n_fail++;
      $display("[TB] FAIL midburst_gnt1: gnt=%b, required 010", gnt);
    end
    expect_accept(1, 1'b0, 8'h31, '0);
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (gnt !== 3'b100) begin
      n_fail++;
      $display("[TB] FAIL midburst_gnt2: gnt=%b, required 100", gnt);
    end
    expect_accept(2, 1'b0, 8'h32, '0);
    next_cycle();
    rst_n  = 1'b0;
    mon_en = 1'b0;
    rd_q.delete();
    cmd_q.delete();
    #1;
    n_cmp++;
    if ({gnt, rvalid, rdata, ram_cs, ram_we, ram_address, ram_data_in} !== '0) begin
      n_fail++;
      $display("[TB] FAIL midburst_reset_outputs: gnt=%b rvalid=%b rdata=%h cs=%b we=%b addr=%h din=%h, required all 0",
               gnt, rvalid, rdata, ram_cs, ram_we, ram_address, ram_data_in);
    end
    next_cycle();
    clear_clients();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      n_cmp++;
      if (ram_cs !== 1'b0 || rvalid !== '0) begin
        n_fail++;
        $display("[TB] FAIL post_reset_quiet step %0d: cs=%b rvalid=%b, required cs=0 rvalid=000",
                 k, ram_cs, rvalid);
      end
    end
    set_client(0, 1'b1, 1'b0, 1'b0, 8'h30, '0);
    set_client(1, 1'b1, 1'b0, 1'b0, 8'h31, '0);
    set_client(2, 1'b1, 1'b0, 1'b0, 8'h32, '0);
    @(negedge clk);
    n_cmp++;
    if (gnt !== 3'b001) begin
      n_fail++;
      $display("[TB] FAIL post_reset_gnt: gnt=%b, required 001", gnt);
    end
    expect_accept(0, 1'b0, 8'h30, '0);
    next_cycle();
    clear_clients();
  endtask

  task automatic drain();
    for (int k = 0; k < 10; k++) begin
      if (rd_q.size() == 0 && cmd_q.size() == 0) break;
      next_cycle();
    end
    next_cycle();
    n_cmp++;
    if (rd_q.size() != 0 || cmd_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain: %0d reads and %0d commands outstanding, required 0 and 0",
               rd_q.size(), cmd_q.size());
    end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_round_robin();
    test_single_client();
    test_lock_burst();
    test_lock_abandon();
    test_wrap_boundary();
    test_reset_midburst();
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ext_ram_arbiter.md
# ext_ram_arbiter

Round-robin arbiter and sequencer for the single-port, synchronous-read external LLR RAM (5-bit words, 256 deep) of the LDPC decoder. It accepts read and write requests from up to NUM_REQ clients, such as the channel-LLR loader, the variable-node update unit and the hard-decision unloader. Each cycle it grants at most one request and drives a registered command onto the RAM port. Read data returns to the issuing client with a fixed latency and a per-client valid strobe. Clients may lock the RAM for bursts.

## Interface
- DATA_WIDTH, 5, RAM word width
- ADDR_WIDTH, 8, RAM address width
- NUM_REQ, 3, number of clients (2..8)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-client request valid
- req_we  in  NUM_REQ  per-client 1=write, 0=read
- req_lock  in  NUM_REQ  per-client: hold ownership after grant while asserted
- req_addr  in  NUM_REQ*ADDR_WIDTH  client i address at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  client i write data at bits [i*DATA_WIDTH +: DATA_WIDTH]
- gnt  out  NUM_REQ  combinational one-hot accept; a request is taken on a cycle with req[i]&gnt[i]
- rvalid  out  NUM_REQ  registered; read data for client i valid this cycle
- rdata  out  DATA_WIDTH  read data, shared by all clients, qualified by rvalid
- ram_address  out  ADDR_WIDTH  registered RAM address
- ram_data_in  out  DATA_WIDTH  registered RAM write data
- ram_we  out  1  registered RAM write enable
- ram_cs  out  1  registered RAM chip select
- ram_data_out  in  DATA_WIDTH  RAM read data, registered inside the RAM

## Operation
- State consists of:
  - rr_ptr, a client index, reset 0.
  - owner_vld and owner_id, the lock owner, reset 0.
  - The command register (ram_*).
  - A 2-stage read-tag pipeline: valid bit plus client id per stage.
- Grant selection, evaluated combinationally each cycle:
  - If owner_vld and req[owner_id] are both set, gnt = onehot(owner_id). No other client is granted.
  - Otherwise, the first i with req[i]=1 is granted, searching i = rr_ptr, rr_ptr+1, … with wrap modulo NUM_REQ.
  - If no req is set, gnt = 0.
  - gnt never depends on req_we, req_addr or req_wdata.
- On an accepted request for client g:
  - ram_cs is set to 1, ram_we to req_we[g], ram_address to addr[g] and ram_data_in to wdata[g] (or 0 if it is a read).
  - rr_ptr is set to (g+1) mod NUM_REQ.
  - owner_vld is set to req_lock[g] and owner_id to g.
- With no accept, ram_cs=0, ram_we=0 and ram_address/ram_data_in hold their values.
- Lock release: owner_vld clears at the first edge where the owner is not accepted, or where the owner is accepted with req_lock low. A locked owner that drops req loses ownership. Round-robin applies in that same cycle.
- Reads push the tag {1, g} into stage 0. Stage 0 moves to stage 1 each cycle. Writes and idle cycles push {0, x}.
- From stage 1: rvalid[id] = 1 and rdata = ram_data_out. All other rvalid bits are 0.
- rdata reads 0 when no rvalid bit is set.
- Commands are issued strictly in grant order. A read granted in the cycle after a write to the same address returns the new data.
- Throughput: one command per cycle, with no bubbles between clients.

## Timing
- Reset (async assert, sync deassert assumed upstream) clears:
  - gnt = 0, rvalid = 0, rdata = 0.
  - ram_cs = 0, ram_we = 0, ram_address = 0, ram_data_in = 0.
  - rr_ptr = 0, owner_vld = 0, tag pipeline = 0.
- A read accepted in cycle t drives ram_cs=1 in cycle t+1 and raises rvalid with data in cycle t+2. Read latency is 2 cycles.
- A write accepted in cycle t is performed at the edge ending cycle t+1.
- Reset asserted mid-operation drops all in-flight reads. No rvalid is emitted for them after reset release.
- Clients must hold req, req_we, addr and wdata stable until accepted. The arbiter does not require this for correctness, but non-accepted values are ignored.
- Out-of-range parameters (NUM_REQ < 2) are not supported.

## Test plan
- Reset check: assert rst_n=0 mid-burst. Within the same cycle all outputs are 0. After release, ram_cs and rvalid stay 0 until a new accept.
- Single client 0:
  - Write addr 0x12 with data 0x1B.
  - Next cycle read addr 0x12.
  - Required: ram_we=1 at t+1, then rvalid[0]=1 with rdata=0x1B two cycles after the read accept.
- Round-robin: hold req=3'b111, all reads, addr = client index.
  - Grants go 0,1,2,0,1,2.
  - rvalid order matches the grants with 2-cycle lag.
  - rdata equals the RAM contents preloaded at addr 0..2.
- Lock burst: client 1 holds req and req_lock for 4 cycles while clients 0 and 2 request.
  - Required: gnt=3'b010 for 4 consecutive cycles.
  - After lock drops, client 2 is granted next (rr_ptr=2).
- Lock abandon: owner 2 drops req with lock still high. Client 0 is granted in the same cycle.
- Wrap and boundary: write addr 0xFF with data 0x1F, then read 0xFF and addr 0x00. Required: rdata 0x1F, then the preloaded value at 0x00.
